// File: rtl/regfile_write_arbiter.sv
// Shares the RF write port between WB (priority, zero latency) and a small MDU result FIFO.
// WB stalls only on a starvation grant; MDU is backpressured via mdu_ready_o when the FIFO is full.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MDU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  wb_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]             wb_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]                 wb_data_i,
  output logic                                  wb_stall_o,
  input  logic                                  mdu_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]             mdu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]                 mdu_data_i,
  output logic                                  mdu_ready_o,
  output logic                                  rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0]             rf_waddr_o,
  output logic [DATA_WIDTH-1:0]                 rf_wdata_o,
  output logic [$clog2(MDU_FIFO_DEPTH+1)-1:0]   fifo_count_o
);

  localparam int CW = $clog2(MDU_FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int PW = (MDU_FIFO_DEPTH > 1) ? $clog2(MDU_FIFO_DEPTH) : 1;

  logic [REG_ADDR_WIDTH-1:0] r_addr_mem [MDU_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     r_data_mem [MDU_FIFO_DEPTH];
  logic [PW-1:0]             r_wptr;
  logic [PW-1:0]             r_rptr;
  logic [CW-1:0]             r_count;
  logic [SW-1:0]             r_starve_cnt;

  logic w_wb_req;
  logic w_fifo_req;
  logic w_grant_fifo;
  logic w_grant_wb;
  logic w_push;
  logic w_pop;

  // WB inputs are masked during reset so nothing reaches the RF while rst_i is high.
  assign w_wb_req     = wb_valid_i && (wb_rd_addr_i != '0) && !rst_i;
  assign w_fifo_req   = (r_count != '0);
  assign w_grant_fifo = w_fifo_req && (!w_wb_req || (r_starve_cnt == SW'(STARVE_LIMIT)));
  assign w_grant_wb   = w_wb_req && !w_grant_fifo;

  assign mdu_ready_o  = (r_count != CW'(MDU_FIFO_DEPTH));
  // rd = 0 results are handshaken but dropped, so they never occupy an entry.
  assign w_push       = mdu_valid_i && mdu_ready_o && (mdu_rd_addr_i != '0);
  assign w_pop        = w_grant_fifo;

  assign wb_stall_o   = w_wb_req && w_grant_fifo;
  assign fifo_count_o = r_count;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (w_grant_fifo) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = r_addr_mem[r_rptr];
      rf_wdata_o = r_data_mem[r_rptr];
    end else if (w_grant_wb) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = wb_rd_addr_i;
      rf_wdata_o = wb_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr_mem[r_wptr] <= mdu_rd_addr_i;
      r_data_mem[r_wptr] <= mdu_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PW'(MDU_FIFO_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PW'(MDU_FIFO_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (w_grant_fifo || !w_fifo_req) begin
      r_starve_cnt <= '0;
    end else if (w_grant_wb && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected RF writes are queued as stimulus is driven
// and popped whenever the DUT asserts rf_we_o.
module tb_regfile_write_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_data_i;
  logic        wb_stall_o;
  logic        mdu_valid_i;
  logic [4:0]  mdu_rd_addr_i;
  logic [31:0] mdu_data_i;
  logic        mdu_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [1:0]  fifo_count_o;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q [$];
  int  checks = 0;
  int  errors = 0;

  regfile_write_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_addr_i  (wb_rd_addr_i),
    .wb_data_i     (wb_data_i),
    .wb_stall_o    (wb_stall_o),
    .mdu_valid_i   (mdu_valid_i),
    .mdu_rd_addr_i (mdu_rd_addr_i),
    .mdu_data_i    (mdu_data_i),
    .mdu_ready_o   (mdu_ready_o),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .fifo_count_o  (fifo_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Checks one cycle mid-period, retires any RF write against the scoreboard, then advances past the edge.
  task automatic step(input string tag, input logic e_we, input logic e_stall,
                      input int e_cnt, input logic e_rdy);
    wr_t w;
    @(negedge clk_i);
    chk({tag, ".we"},    {31'd0, rf_we_o},     {31'd0, e_we});
    chk({tag, ".stall"}, {31'd0, wb_stall_o},  {31'd0, e_stall});
    chk({tag, ".count"}, {30'd0, fifo_count_o}, 32'(e_cnt));
    chk({tag, ".ready"}, {31'd0, mdu_ready_o}, {31'd0, e_rdy});
    if (rf_we_o === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL %s.unexpected_write: observed addr %0d data %0h expected no write",
               tag, rf_waddr_o, rf_wdata_o);
      end
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk({tag, ".waddr"}, {27'd0, rf_waddr_o}, {27'd0, w.addr});
        chk({tag, ".wdata"}, rf_wdata_o, w.data);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid_i   = v;
    wb_rd_addr_i = a;
    wb_data_i    = d;
  endtask

  task automatic set_mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
    mdu_valid_i   = v;
    mdu_rd_addr_i = a;
    mdu_data_i    = d;
  endtask

  initial begin
    rst_i = 1'b1;
    set_wb(1'b1, 5'd2, 32'h2222);
    set_mdu(1'b1, 5'd5, 32'h5555);

    // Reset with both sources active.
    step("rst0", 1'b0, 1'b0, 0, 1'b1);
    step("rst1", 1'b0, 1'b0, 0, 1'b1);
    rst_i = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    set_mdu(1'b1, 5'd7, 32'hDEAD_BEEF);
    step("push7", 1'b0, 1'b0, 0, 1'b1);
    set_mdu(1'b0, 5'd0, 32'h0);
    expect_write(5'd7, 32'hDEAD_BEEF);
    step("drain7", 1'b1, 1'b0, 1, 1'b1);
    step("idle0", 1'b0, 1'b0, 0, 1'b1);

    // Pipeline priority over a buffered entry.
    set_mdu(1'b1, 5'd4, 32'h44);
    step("push4", 1'b0, 1'b0, 0, 1'b1);
    set_mdu(1'b0, 5'd0, 32'h0);
    set_wb(1'b1, 5'd3, 32'h11);
    expect_write(5'd3, 32'h11);
    step("wb3", 1'b1, 1'b0, 1, 1'b1);
    set_wb(1'b0, 5'd0, 32'h0);
    expect_write(5'd4, 32'h44);
    step("drain4", 1'b1, 1'b0, 1, 1'b1);
    step("idle1", 1'b0, 1'b0, 0, 1'b1);

    // Starvation: four WB wins, then a forced FIFO grant stalling WB, then WB wins.
    set_mdu(1'b1, 5'd9, 32'h99);
    step("push9", 1'b0, 1'b0, 0, 1'b1);
    set_mdu(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      set_wb(1'b1, 5'(10 + i), 32'h100 + 32'(i));
      expect_write(5'(10 + i), 32'h100 + 32'(i));
      step("starve_wb", 1'b1, 1'b0, 1, 1'b1);
    end
    set_wb(1'b1, 5'd14, 32'h104);
    expect_write(5'd9, 32'h99);
    step("starve_grant", 1'b1, 1'b1, 1, 1'b1);
    expect_write(5'd14, 32'h104);
    step("stalled_wb", 1'b1, 1'b0, 0, 1'b1);

    // Full FIFO under continuous WB, then drain in push order.
    set_wb(1'b1, 5'd20, 32'h200);
    set_mdu(1'b1, 5'd21, 32'hA1);
    expect_write(5'd20, 32'h200);
    step("full_a", 1'b1, 1'b0, 0, 1'b1);
    set_wb(1'b1, 5'd20, 32'h201);
    set_mdu(1'b1, 5'd22, 32'hA2);
    expect_write(5'd20, 32'h201);
    step("full_b", 1'b1, 1'b0, 1, 1'b1);
    set_wb(1'b1, 5'd20, 32'h202);
    set_mdu(1'b1, 5'd23, 32'hA3);
    expect_write(5'd20, 32'h202);
    step("full_c", 1'b1, 1'b0, 2, 1'b0);
    set_wb(1'b0, 5'd0, 32'h0);
    expect_write(5'd21, 32'hA1);
    step("full_d", 1'b1, 1'b0, 2, 1'b0);
    set_mdu(1'b0, 5'd0, 32'h0);
    expect_write(5'd22, 32'hA2);
    step("full_e", 1'b1, 1'b0, 1, 1'b1);
    step("full_f", 1'b0, 1'b0, 0, 1'b1);

    // x0 handling on both sources.
    set_mdu(1'b1, 5'd25, 32'h55);
    step("push25", 1'b0, 1'b0, 0, 1'b1);
    set_mdu(1'b0, 5'd0, 32'h0);
    set_wb(1'b1, 5'd0, 32'hBAD);
    expect_write(5'd25, 32'h55);
    step("wb_x0_drain", 1'b1, 1'b0, 1, 1'b1);
    set_mdu(1'b1, 5'd0, 32'h77);
    step("mdu_x0_push", 1'b0, 1'b0, 0, 1'b1);
    set_mdu(1'b0, 5'd0, 32'h0);
    step("mdu_x0_after", 1'b0, 1'b0, 0, 1'b1);

    // Build count = 2, starve = 3, then reset asynchronously mid-cycle.
    set_wb(1'b1, 5'd26, 32'h300);
    set_mdu(1'b1, 5'd27, 32'hB1);
    expect_write(5'd26, 32'h300);
    step("mid_1", 1'b1, 1'b0, 0, 1'b1);
    set_wb(1'b1, 5'd26, 32'h301);
    set_mdu(1'b1, 5'd28, 32'hB2);
    expect_write(5'd26, 32'h301);
    step("mid_2", 1'b1, 1'b0, 1, 1'b1);
    set_mdu(1'b0, 5'd0, 32'h0);
    set_wb(1'b1, 5'd26, 32'h302);
    expect_write(5'd26, 32'h302);
    step("mid_3", 1'b1, 1'b0, 2, 1'b0);
    set_wb(1'b1, 5'd26, 32'h303);
    expect_write(5'd26, 32'h303);
    step("mid_4", 1'b1, 1'b0, 2, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst.count", {30'd0, fifo_count_o}, 32'd0);
    chk("async_rst.we",    {31'd0, rf_we_o},      32'd0);
    chk("async_rst.stall", {31'd0, wb_stall_o},   32'd0);
    chk("async_rst.ready", {31'd0, mdu_ready_o},  32'd1);
    step("rst_hold", 1'b0, 1'b0, 0, 1'b1);
    rst_i = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    step("post_rst0", 1'b0, 1'b0, 0, 1'b1);
    step("post_rst1", 1'b0, 1'b0, 0, 1'b1);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_drained: observed %0d pending writes expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the in-order pipeline writeback (the `result_w` produced by the writeback stage) and the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small FIFO and drained into idle write-port cycles. The pipeline normally has priority, and a starvation counter forces an MDU drain when the pipeline has monopolised the port for too long. Sits between the writeback stage / MDU and the register file write port, and drives a stall request back to the hazard unit.

## Interface
- `DATA_WIDTH`, default 32: write data width.
- `REG_ADDR_WIDTH`, default 5: destination register address width.
- `MDU_FIFO_DEPTH`, default 2: MDU result buffer entries; must be ≥ 1.
- `STARVE_LIMIT`, default 4: consecutive lost cycles before the MDU FIFO is forced a grant; must be ≥ 1.
- `clk_i` input 1: clock, rising edge. One clock for the whole block.
- `rst_i` input 1: reset, asynchronous, active-high.
- `wb_valid_i` input 1: pipeline writeback has a result this cycle (RegWrite in WB).
- `wb_rd_addr_i` input REG_ADDR_WIDTH: pipeline destination register.
- `wb_data_i` input DATA_WIDTH: pipeline result (`result_w`).
- `wb_stall_o` output 1: pipeline must hold WB this cycle; the write is not performed.
- `mdu_valid_i` input 1: MDU result available.
- `mdu_rd_addr_i` input REG_ADDR_WIDTH: MDU destination register.
- `mdu_data_i` input DATA_WIDTH: MDU result.
- `mdu_ready_o` output 1: FIFO can accept; the transfer occurs when `mdu_valid_i && mdu_ready_o` at the rising edge.
- `rf_we_o` output 1: register file write enable.
- `rf_waddr_o` output REG_ADDR_WIDTH: register file write address.
- `rf_wdata_o` output DATA_WIDTH: register file write data.
- `fifo_count_o` output $clog2(MDU_FIFO_DEPTH+1): number of buffered MDU results.

## Operation
- **Requests**
  - `wb_req = wb_valid_i && (wb_rd_addr_i != 0)`.
  - `fifo_req = (count != 0)`.
- **Enqueue**
  - `mdu_ready_o = (count != MDU_FIFO_DEPTH)`, driven from the registered count only.
  - An accepted MDU result with rd = 0 is consumed and discarded; it is not stored.
  - No enqueue-to-output bypass: a newly written entry becomes the head at the earliest in the next cycle.
- **Arbitration** (combinational, each cycle)
  - `grant_fifo = fifo_req && (!wb_req || starve_cnt == STARVE_LIMIT)`.
  - `grant_wb = wb_req && !grant_fifo`.
- **Write port** (combinational from the grant)
  - On `grant_wb`: `rf_we_o = 1`, addr/data taken from the `wb_*` inputs.
  - On `grant_fifo`: `rf_we_o = 1`, addr/data taken from the FIFO head; the head pops at the clock edge.
  - With no grant: `rf_we_o = 0`, and addr/data are 0.
- **Stall**
  - `wb_stall_o = wb_req && grant_fifo`.
  - A WB with rd = 0 is never stalled and never writes.
- **Starvation counter** `starve_cnt`, width $clog2(STARVE_LIMIT+1):
  - Increments, saturating at STARVE_LIMIT, when `fifo_req && grant_wb`.
  - Clears to 0 when `grant_fifo` or `!fifo_req`.
- **Simultaneous push and pop**
  - Allowed when count < depth; count is unchanged and order is preserved.
  - When full, `mdu_ready_o = 0`, so no push occurs even if a pop happens that cycle.
- **Ordering**: the block does not check for a RAW/WAW conflict between a WB and a buffered MDU entry with the same rd. The hazard unit uses `fifo_count_o` and its own scoreboard to prevent it.

## Timing
- **Reset** (asynchronous assert, takes effect immediately)
  - FIFO is emptied: pointers = 0, count = 0, and `starve_cnt = 0`.
  - Resulting outputs: `fifo_count_o = 0`, `mdu_ready_o = 1`, `rf_we_o = 0` (no requests in the FIFO, and `wb_*` inputs are ignored while `rst_i` is high), `wb_stall_o = 0`, `rf_waddr_o = 0`, `rf_wdata_o = 0`.
  - Buffered results are lost on reset mid-operation.
- **Latency**
  - WB writes in the same cycle it is presented, with zero added latency.
  - An MDU result accepted at edge N can write at the earliest in cycle N (the cycle following edge N).
- **Maximum WB stall**: 1 cycle per starvation grant. A stalled WB re-presents the next cycle with `starve_cnt = 0`, so it wins that cycle.
- **Pointer wrap**: read and write pointers wrap modulo MDU_FIFO_DEPTH; depth does not need to be a power of two.

## Test plan
- **Reset**: assert `rst_i` with `mdu_valid_i = 1` and `wb_valid_i = 1`.
  - Required: `rf_we_o = 0`, `wb_stall_o = 0`, `fifo_count_o = 0`, `mdu_ready_o = 1`.
  - Then deassert and push an MDU result (rd = 7, data = 0xDEAD_BEEF) with `wb_valid_i = 0`.
  - Required next cycle: `rf_we_o = 1`, `rf_waddr_o = 7`, `rf_wdata_o = 0xDEADBEEF`, `fifo_count_o` 1 → 0.
- **Pipeline priority**: `wb_valid_i = 1`, rd = 3, data = 0x11, with the FIFO holding one entry.
  - Required: WB writes x3 = 0x11 and `wb_stall_o = 0`.
  - FIFO entry writes in the first cycle `wb_valid_i = 0`.
- **Starvation**: FIFO holds rd = 9 / 0x99; WB is valid every cycle with STARVE_LIMIT = 4.
  - Required: WB is granted in cycles 1–4.
  - Cycle 5: FIFO is granted (x9 = 0x99) with `wb_stall_o = 1`.
  - Cycle 6: the stalled WB is granted and the counter is back at 0.
- **Full FIFO**: with WB continuously valid, push 2 MDU results.
  - Required: `mdu_ready_o = 0`, and a third `mdu_valid_i` is not accepted.
  - Then drop WB; the two entries write in push order over 2 cycles, and `mdu_ready_o` returns to 1 after the first pop.
- **x0 handling**:
  - WB with rd = 0: `rf_we_o = 0` and no stall, and a nonempty FIFO drains that cycle.
  - MDU push with rd = 0: accepted, and `fifo_count_o` stays unchanged.
- **Reset mid-operation**: FIFO count = 2 and `starve_cnt = 3`, then assert `rst_i` asynchronously between edges.
  - Required immediately: `fifo_count_o = 0`, `rf_we_o = 0`.
  - After release: no stale entries are written.
